// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word reads to a fixed
// latency-1 instruction memory, queues the returned words with their fetch
// addresses in a small prefetch FIFO, and presents them to the consumer with
// a valid/ready handshake. A redirect flushes everything in flight and
// restarts fetching at the new target.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rsp_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [XLEN-1:0]            instr_data,
    output logic [XLEN-1:0]            instr_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Occupancy plus one in-flight slot needs one more bit than fifo_count.
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Fetch address of the next request, and the address of the last issued
    // request (which is also the address of the response arriving this cycle).
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] addr_reg;
    logic            inflight_reg;

    // Prefetch FIFO storage and bookkeeping.
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_target;

    // The two low bits of the redirect target are forced to zero, so only
    // the word-address part of redirect_pc is consumed.
    logic            redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};

    // A slot is reserved for a response from the moment its request issues,
    // so a landing response always finds room without needing pop credit.
    assign credit_used = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};

    // A response is discarded when a redirect occurs in the cycle it lands;
    // the redirect also blocks the consumer from popping that cycle.
    assign push = inflight_reg && !redirect_valid;
    assign pop  = (count_reg != '0) && instr_ready && !redirect_valid;

    // Control FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and issue decision: BOOT idles for one clock, RUN issues
    // whenever fetching is enabled, no redirect is pending and credit exists.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                issue = fetch_en && !redirect_valid && (credit_used < DEPTH_W);
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Fetch PC, last issued address and in-flight marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            addr_reg     <= RESET_PC;
            inflight_reg <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg       <= redirect_target;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                addr_reg <= pc_reg;
                pc_reg   <= pc_reg + XLEN'(4);
            end
        end
    end

    // The request address tracks the fetch PC while requesting and otherwise
    // holds the address of the most recent request.
    assign imem_req_valid = issue;
    assign imem_addr      = issue ? pc_reg : addr_reg;

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect_valid) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage: the landing word is stored with the address it came from.
    // Contents need no reset because occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= addr_reg;
        end
    end

    // Head of the queue is presented directly; it only moves on a pop, so it
    // stays stable while the consumer stalls.
    assign instr_valid = (count_reg != '0);
    assign instr_data  = data_mem[rd_ptr_reg];
    assign instr_pc    = pc_mem[rd_ptr_reg];
    assign fifo_count  = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  fifo_count;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_addr     (imem_addr),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: queue of fetched (pc, data) pairs, the next
    // fetch address, the address of the last request and a pending response.
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_last;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];

    // DUT outputs observed in the most recent cycle.
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_data;
    logic [2:0]  obs_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = 32'h0;
        m_last = 32'h0;
        m_pend = 1'b0;
        q_pc.delete();
        q_data.delete();
    endtask

    // Memory returns addr + 0x100; when nothing is due the data bus carries
    // random garbage so a wrongly accepted word would be noticed.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    // One clock cycle: drive inputs, check outputs at the falling edge
    // against the model, then advance the model across the rising edge.
    task automatic cycle(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          e_req;
        logic [31:0] e_addr;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_rsp_data  = m_pend ? mem_word(m_pend_pc) : $urandom;
        @(negedge clk);
        e_req  = !m_boot && fe && !rv && (q_pc.size() + int'(m_pend) < 4);
        e_addr = e_req ? m_pc : m_last;
        obs_req   = imem_req_valid;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_data  = instr_data;
        obs_cnt   = fifo_count;
        check_eq("req_valid", 32'(imem_req_valid), 32'(e_req));
        check_eq("imem_addr", imem_addr, e_addr);
        check_eq("fifo_count", 32'(fifo_count), 32'(q_pc.size()));
        check_eq("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            check_eq("instr_pc", instr_pc, q_pc[0]);
            check_eq("instr_data", instr_data, q_data[0]);
        end
        if (rv) begin
            q_pc.delete();
            q_data.delete();
            m_pend = 1'b0;
            m_pc   = {rpc[31:2], 2'b00};
        end else begin
            if (q_pc.size() != 0 && rdy) begin
                void'(q_pc.pop_front());
                void'(q_data.pop_front());
            end
            if (m_pend) begin
                q_pc.push_back(m_pend_pc);
                q_data.push_back(mem_word(m_pend_pc));
            end
            m_pend = e_req;
            if (e_req) begin
                m_pend_pc = m_pc;
                m_last    = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
        m_boot = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check the asynchronous clear, then release
    // just after the next rising edge.
    task automatic apply_reset();
        fetch_en = 1'b1;
        reset    = 1'b0;
        #1;
        check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_fifo_count", 32'(fifo_count), 32'h0);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        imem_rsp_data  = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("init_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("init_imem_addr", imem_addr, 32'h0);
        check_eq("init_instr_valid", 32'(instr_valid), 32'h0);
        check_eq("init_fifo_count", 32'(fifo_count), 32'h0);
        reset = 1'b1;

        // Sequential fetch with the consumer always ready.
        cycle(1, 0, 0, 1);
        check_eq("boot_no_req", 32'(obs_req), 32'h0);
        cycle(1, 0, 0, 1);
        check_eq("seq_req0", 32'(obs_req), 32'h1);
        check_eq("seq_addr0", obs_addr, 32'h0);
        cycle(1, 0, 0, 1);
        check_eq("seq_addr1", obs_addr, 32'h4);
        cycle(1, 0, 0, 1);
        check_eq("seq_addr2", obs_addr, 32'h8);
        check_eq("seq_pc0", obs_pc, 32'h0);
        check_eq("seq_data0", obs_data, 32'h100);
        cycle(1, 0, 0, 1);
        check_eq("seq_pc1", obs_pc, 32'h4);
        check_eq("seq_data1", obs_data, 32'h104);

        // Stalled consumer: FIFO fills to 4 and issue stops; drain in order.
        apply_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        check_eq("sat_count", 32'(obs_cnt), 32'h4);
        check_eq("sat_no_req", 32'(obs_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1);
            check_eq("drain_pc", obs_pc, 32'(i * 4));
        end
        cycle(0, 0, 0, 0);
        check_eq("drain_empty", 32'(obs_cnt), 32'h0);

        // Redirect on the cycle after the request to 0x10.
        cycle(1, 0, 0, 1);
        check_eq("pre_redir_addr", obs_addr, 32'h10);
        cycle(1, 1, 32'h2003, 1);
        check_eq("redir_no_req", 32'(obs_req), 32'h0);
        cycle(1, 0, 0, 1);
        check_eq("redir_flushed", 32'(obs_cnt), 32'h0);
        check_eq("redir_addr", obs_addr, 32'h2000);
        cycle(1, 0, 0, 1);
        check_eq("redir_still_empty", 32'(obs_cnt), 32'h0);
        cycle(1, 0, 0, 1);
        check_eq("redir_first_pc", obs_pc, 32'h2000);

        // fetch_en dropped with one request outstanding.
        cycle(0, 1, 32'h3000, 0);
        cycle(1, 0, 0, 0);
        check_eq("fe_last_req", obs_addr, 32'h3000);
        cycle(0, 0, 0, 0);
        check_eq("fe_off_no_req", 32'(obs_req), 32'h0);
        cycle(0, 0, 0, 0);
        check_eq("fe_off_landed", 32'(obs_cnt), 32'h1);
        cycle(0, 0, 0, 1);
        check_eq("fe_off_pc", obs_pc, 32'h3000);
        cycle(0, 0, 0, 0);
        check_eq("fe_off_drained", 32'(obs_cnt), 32'h0);

        // Address wrap at the top of the address space.
        cycle(1, 1, 32'hFFFF_FFF8, 1);
        cycle(1, 0, 0, 1);
        check_eq("wrap_addr0", obs_addr, 32'hFFFF_FFF8);
        cycle(1, 0, 0, 1);
        check_eq("wrap_addr1", obs_addr, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 1);
        check_eq("wrap_addr2", obs_addr, 32'h0000_0000);

        // Randomized traffic, including redirects near the wrap point.
        for (int i = 0; i < 800; i++) begin
            bit          fe;
            bit          rv;
            bit          rdy;
            logic [31:0] rpc;
            fe  = ($urandom_range(9) < 8);
            rv  = ($urandom_range(15) == 0);
            rdy = ($urandom_range(9) < 6);
            rpc = $urandom;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            cycle(fe, rv, rpc, rdy);
        end

        // Reset with three entries queued clears the FIFO immediately.
        cycle(0, 1, 32'h500, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_eq("three_queued", 32'(obs_cnt), 32'h3);
        apply_reset();
        cycle(1, 0, 0, 1);
        check_eq("post_rst_boot", 32'(obs_req), 32'h0);
        cycle(1, 0, 0, 1);
        check_eq("post_rst_req", 32'(obs_req), 32'h1);
        check_eq("post_rst_addr", obs_addr, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
